lutram_fifo64: RTL
==================

Name: lutram_fifo64

Overview:
- Synchronous 64-deep first-word-fall-through FIFO built on RAM64M distributed-RAM storage.
- Write side is the producer. Read side is the consumer end, taking data out of the LUT-RAM in order.
- Used as a small elastic buffer between single-clock pipeline stages.
- Verilator-compatible, like the rest of the primitive library.

Parameters:
- DATA_W, 6, data width in bits, legal range 1..48; storage uses ceil(DATA_W/3) RAM64M instances.
- AFULL_THR, 56, LEVEL value at or above which AFULL asserts, legal range 1..64.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-high.
- WR_EN  in  1  write request.
- WR_DATA  in  DATA_W  write data.
- FULL  out  1  storage holds 64 entries; writes are refused.
- AFULL  out  1  LEVEL >= AFULL_THR.
- RD_EN  in  1  read (pop) request.
- RD_DATA  out  DATA_W  head-of-FIFO data; valid only while EMPTY=0.
- EMPTY  out  1  no readable entry.
- LEVEL  out  7  number of entries held, 0..64 (0..65 with the optional feature).
- ERR_OVF  out  1  one-cycle pulse when a write is refused.
- ERR_UDF  out  1  one-cycle pulse when a read is refused.

Behaviour:
- Reset (synchronous, RST=1 at an edge):
  - wr_ptr=0, rd_ptr=0, LEVEL=0, EMPTY=1, FULL=0, AFULL=0, ERR_OVF=0, ERR_UDF=0.
  - RAM contents are not cleared.
  - RST overrides any same-cycle WR_EN/RD_EN. Reset mid-stream discards all entries.
- Accepted write: WR_EN=1 and FULL=0.
  - Storage write at wr_ptr.
  - wr_ptr advances modulo 64 (6-bit natural wrap).
- Accepted read: RD_EN=1 and EMPTY=0.
  - rd_ptr advances modulo 64.
- Refused operations:
  - WR_EN=1 with FULL=1: no state change; ERR_OVF=1 for the next cycle.
  - RD_EN=1 with EMPTY=1: no state change; ERR_UDF=1 for the next cycle.
- LEVEL arithmetic, 7-bit:
  - +1 for a write only, -1 for a read only, unchanged when both are accepted.
- Flags are registered from the next LEVEL value, so they are correct in the cycle after the edge:
  - FULL = (LEVEL==64).
  - EMPTY = (LEVEL==0).
  - AFULL = (LEVEL >= AFULL_THR).
- RD_DATA is the asynchronous RAM read at rd_ptr (RAM64M ports A–C).
  - Port D address = wr_ptr, and it carries the write.
  - Write-to-visible latency: a write at edge N gives EMPTY=0 and correct RD_DATA after edge N.
- Simultaneous WR_EN and RD_EN:
  - While full: the read is accepted and the write is refused (ERR_OVF pulses); there is no same-cycle bypass.
  - While empty: the write is accepted and the read is refused (ERR_UDF pulses).
- Pointer wrap: after 64 writes wr_ptr returns to 0. Full and empty are distinguished by LEVEL, not by pointer equality.

Optional Feature:
- Macro: LUTRAM_FIFO64_OUTREG_EN.
- When defined:
  - RD_DATA comes from a registered output stage that holds the head entry.
  - The RAM is prefetched into the stage whenever the stage is empty, or is being popped, and the RAM is non-empty.
  - Write-to-EMPTY-deassert latency becomes 2 edges.
  - LEVEL = RAM count + stage-valid, range 0..65. FULL still means RAM count==64.
  - A pop and a refill in the same cycle keep RD_DATA streaming at one word per cycle.
- When undefined: the behaviour is exactly as above (combinational read path, 64-entry capacity).

Decomposition:
- Package lutram_fifo64_pkg holds:
  - DEPTH=64, PTR_W=6, LVL_W=7.
  - Function n_ram(DATA_W) = (DATA_W+2)/3.
- Sub-module lutram_fifo64_mem: generate loop of RAM64M instances.
  - Pads the last instance's unused bits with 0.
  - WE is shared; port D address = wr_ptr; A–C address = rd_ptr.
- Pointer, level and flag logic stay in the top module.

Test Plan:
- Reset, then write 0x15, 0x2A, 0x3F: after the third edge LEVEL=3, EMPTY=0, RD_DATA=0x15. Three pops give 0x15, 0x2A, 0x3F, then EMPTY=1.
- Fill with 0..63:
  - AFULL rises after the 56th write.
  - FULL=1 after the 64th write.
  - A 65th write (value 0x3F) gives ERR_OVF=1 for one cycle, LEVEL stays 64, and the data is not stored.
- RD_EN on an empty FIFO: ERR_UDF pulses once, and LEVEL and pointers are unchanged.
- Simultaneous write and read at LEVEL=10 for 100 cycles with incrementing data:
  - LEVEL stays 10.
  - Output order is exact across the 64-entry pointer wrap.
- Full FIFO with simultaneous WR_EN and RD_EN: the read is accepted, the write is refused, ERR_OVF=1 and LEVEL=63.
- Assert RST with LEVEL=20 and WR_EN=1 in the same cycle: next cycle LEVEL=0, EMPTY=1, FULL=0. With LUTRAM_FIFO64_OUTREG_EN defined, also check the 2-edge EMPTY latency and back-to-back streaming.

Source files
------------

// File: rtl/lutram_fifo64_pkg.sv
// rtl/lutram_fifo64_pkg.sv - shared sizing constants and types for lutram_fifo64
package lutram_fifo64_pkg;

  localparam int DEPTH = 64;
  localparam int PTR_W = 6;
  localparam int LVL_W = 7;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [LVL_W-1:0] lvl_t;

  function automatic int n_ram(input int data_w);
    return (data_w + 2) / 3;
  endfunction

endpackage

// File: rtl/RAM64M.sv
// rtl/RAM64M.sv - behavioural 64x4 quad-port distributed RAM (three read ports, one read/write port)
module RAM64M (
  output logic       DOA,
  output logic       DOB,
  output logic       DOC,
  output logic       DOD,
  input  logic       DIA,
  input  logic       DIB,
  input  logic       DIC,
  input  logic       DID,
  input  logic [5:0] ADDRA,
  input  logic [5:0] ADDRB,
  input  logic [5:0] ADDRC,
  input  logic [5:0] ADDRD,
  input  logic       WE,
  input  logic       WCLK
);

  logic [63:0] mem_a;
  logic [63:0] mem_b;
  logic [63:0] mem_c;
  logic [63:0] mem_d;

  // All four bit-planes are written at the port D address, as in the primitive.
  always_ff @(posedge WCLK) begin
    if (WE) begin
      mem_a[ADDRD] <= DIA;
      mem_b[ADDRD] <= DIB;
      mem_c[ADDRD] <= DIC;
      mem_d[ADDRD] <= DID;
    end
  end

  assign DOA = mem_a[ADDRA];
  assign DOB = mem_b[ADDRB];
  assign DOC = mem_c[ADDRC];
  assign DOD = mem_d[ADDRD];

endmodule

// File: rtl/lutram_fifo64_mem.sv
// rtl/lutram_fifo64_mem.sv - 64-deep storage built from ceil(DATA_W/3) RAM64M slices
module lutram_fifo64_mem
  import lutram_fifo64_pkg::*;
#(
  parameter int DATA_W = 6
) (
  input  logic              WCLK,
  input  logic              we,
  input  ptr_t              wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  ptr_t              rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int NRAM  = n_ram(DATA_W);
  localparam int PAD_W = 3 * NRAM;

  logic [PAD_W-1:0] din_pad;
  logic [PAD_W-1:0] dout_pad;
  logic [NRAM-1:0]  dod_unused;

  assign din_pad = PAD_W'(wr_data);
  assign rd_data = dout_pad[DATA_W-1:0];

  // Ports A-C carry three data bits each; port D only supplies the write address.
  for (genvar i = 0; i < NRAM; i++) begin : g_ram
    RAM64M u_ram (
      .DOA   (dout_pad[3*i]),
      .DOB   (dout_pad[3*i+1]),
      .DOC   (dout_pad[3*i+2]),
      .DOD   (dod_unused[i]),
      .DIA   (din_pad[3*i]),
      .DIB   (din_pad[3*i+1]),
      .DIC   (din_pad[3*i+2]),
      .DID   (1'b0),
      .ADDRA (rd_addr),
      .ADDRB (rd_addr),
      .ADDRC (rd_addr),
      .ADDRD (wr_addr),
      .WE    (we),
      .WCLK  (WCLK)
    );
  end

  if (PAD_W > DATA_W) begin : g_pad
    logic pad_unused;
    assign pad_unused = &{1'b0, dout_pad[PAD_W-1:DATA_W]};
  end

endmodule

// File: rtl/lutram_fifo64.sv
// rtl/lutram_fifo64.sv - 64-deep FWFT FIFO on distributed RAM
// Optional registered read stage: LUTRAM_FIFO64_OUTREG_EN
module lutram_fifo64
  import lutram_fifo64_pkg::*;
#(
  parameter int DATA_W    = 6,
  parameter int AFULL_THR = 56
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              FULL,
  output logic              AFULL,
  input  logic              RD_EN,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              EMPTY,
  output logic [6:0]        LEVEL,
  output logic              ERR_OVF,
  output logic              ERR_UDF
);

  ptr_t              wr_ptr;
  ptr_t              rd_ptr;
  lvl_t              level_q;
  logic              full_q;
  logic              empty_q;
  logic              afull_q;
  logic              ovf_q;
  logic              udf_q;
  logic [DATA_W-1:0] ram_rd;

  logic wr_acc;
  logic rd_adv;
  logic udf_nxt;
  logic empty_nxt;
  logic full_nxt;
  lvl_t level_nxt;

  lutram_fifo64_mem #(.DATA_W(DATA_W)) u_mem (
    .WCLK    (CLK),
    .we      (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (WR_DATA),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd)
  );

  // full_q tracks RAM occupancy only, so the write side never sees the output stage.
  assign wr_acc = WR_EN & ~full_q;

`ifdef LUTRAM_FIFO64_OUTREG_EN
  lvl_t              ram_cnt_q;
  lvl_t              ram_cnt_nxt;
  logic              stage_vld_q;
  logic              stage_vld_nxt;
  logic [DATA_W-1:0] stage_data_q;
  logic              pop;

  always_comb begin
    pop           = RD_EN & stage_vld_q;
    udf_nxt       = RD_EN & ~stage_vld_q;
    rd_adv        = (ram_cnt_q != '0) & (~stage_vld_q | pop);
    ram_cnt_nxt   = ram_cnt_q + LVL_W'(wr_acc) - LVL_W'(rd_adv);
    stage_vld_nxt = rd_adv | (stage_vld_q & ~pop);
    level_nxt     = ram_cnt_nxt + LVL_W'(stage_vld_nxt);
    empty_nxt     = ~stage_vld_nxt;
    full_nxt      = (ram_cnt_nxt == LVL_W'(DEPTH));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ram_cnt_q    <= '0;
      stage_vld_q  <= 1'b0;
      stage_data_q <= '0;
    end else begin
      ram_cnt_q   <= ram_cnt_nxt;
      stage_vld_q <= stage_vld_nxt;
      if (rd_adv) begin
        stage_data_q <= ram_rd;
      end
    end
  end

  assign RD_DATA = stage_data_q;
`else
  always_comb begin
    rd_adv    = RD_EN & ~empty_q;
    udf_nxt   = RD_EN & empty_q;
    level_nxt = level_q + LVL_W'(wr_acc) - LVL_W'(rd_adv);
    empty_nxt = (level_nxt == '0);
    full_nxt  = (level_nxt == LVL_W'(DEPTH));
  end

  assign RD_DATA = ram_rd;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level_q <= level_nxt;
      full_q  <= full_nxt;
      empty_q <= empty_nxt;
      afull_q <= (level_nxt >= LVL_W'(AFULL_THR));
      ovf_q   <= WR_EN & full_q;
      udf_q   <= udf_nxt;
    end
  end

  assign FULL    = full_q;
  assign EMPTY   = empty_q;
  assign AFULL   = afull_q;
  assign LEVEL   = level_q;
  assign ERR_OVF = ovf_q;
  assign ERR_UDF = udf_q;

endmodule
